// File: rtl/seq_gen_pkg.sv
// Shared encodings for the parametrised sequence generator: the mode
// codes seen on the mode input and the controller state enum.
package seq_gen_pkg;

    localparam logic [1:0] MODE_FIB = 2'd0;
    localparam logic [1:0] MODE_TRI = 2'd1;
    localparam logic [1:0] MODE_SQR = 2'd2;
    localparam logic [1:0] MODE_RSV = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_FAULT
    } state_t;

endpackage

// File: rtl/seq_gen_step.sv
// Combinational next-term datapath. Given the current term acc, the term
// before it (prev, used only by Fibonacci) and the current index k, it
// produces term k+1 one bit wider than the data path, plus a carry flag
// that is set whenever the true sum does not fit in DATA_WIDTH bits.
module seq_gen_step
    import seq_gen_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ORDER_WIDTH = 16
) (
    input  logic [1:0]             mode,
    input  logic [DATA_WIDTH-1:0]  acc,
    input  logic [DATA_WIDTH-1:0]  prev,
    input  logic [ORDER_WIDTH-1:0] k,
    output logic [DATA_WIDTH:0]    next,
    output logic                   carry
);

    // The sum is formed wide enough to hold both the data term and the
    // largest index-derived increment (2k+1), so a narrow data path with
    // a wide order never loses an increment bit before overflow is judged.
    localparam int SW = ((DATA_WIDTH > ORDER_WIDTH + 1) ? DATA_WIDTH : ORDER_WIDTH + 1) + 1;

    logic [SW-1:0] sum;

    // Select the recurrence: FIB adds the previous term, TRI adds k+1,
    // SQR adds 2(k+1)-1 = 2k+1; the reserved mode just passes acc through.
    always_comb begin
        sum = SW'(acc);
        case (mode)
            MODE_FIB: sum = SW'(acc) + SW'(prev);
            MODE_TRI: sum = SW'(acc) + SW'(k) + SW'(1);
            MODE_SQR: sum = SW'(acc) + (SW'(k) << 1) + SW'(1);
            default:  sum = SW'(acc);
        endcase
    end

    assign next  = sum[DATA_WIDTH:0];
    assign carry = |sum[SW-1:DATA_WIDTH];

endmodule

// File: rtl/seq_gen_param.sv
// Parametrised sequence generator. Computes term ORDER of a seeded
// Fibonacci, triangle or square sequence, flags illegal modes and data
// overflow, and can optionally stream every intermediate term through a
// valid/ready port where each step waits for the consumer.
module seq_gen_param
    import seq_gen_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ORDER_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [1:0]             mode,
    input  logic                   stream,
    input  logic                   clear,
    input  logic [ORDER_WIDTH-1:0] order,
    input  logic [DATA_WIDTH-1:0]  data_in,
    output logic                   done,
    output logic                   error,
    output logic                   overflow,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   term_valid,
    input  logic                   term_ready,
    output logic [DATA_WIDTH-1:0]  term_out,
    output logic [ORDER_WIDTH-1:0] term_idx
);

    state_t                 state;
    logic [DATA_WIDTH-1:0]  acc;
    logic [DATA_WIDTH-1:0]  prev;
    logic [ORDER_WIDTH-1:0] k;
    logic [ORDER_WIDTH-1:0] order_q;
    logic [1:0]             mode_q;
    logic                   stream_q;

    logic [DATA_WIDTH:0]    next;
    logic                   carry;
    logic                   step;
    logic                   too_big;

    seq_gen_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .ORDER_WIDTH(ORDER_WIDTH)
    ) u_step (
        .mode (mode_q),
        .acc  (acc),
        .prev (prev),
        .k    (k),
        .next (next),
        .carry(carry)
    );

    // In streaming mode a step only happens when the current term is
    // handed over; otherwise the generator advances every cycle.
    assign step    = stream_q ? (term_valid && term_ready) : 1'b1;
    assign too_big = carry || next[DATA_WIDTH];

    // The stream port always shows the live accumulator and index; they
    // only move on a step, so they are stable while the consumer stalls.
    assign term_out = acc;
    assign term_idx = k;

    // Controller: clear behaves exactly like reset and wins over load.
    // DONE accepts a new load just like IDLE; FAULT waits for clear/reset.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state      <= ST_IDLE;
            acc        <= '0;
            prev       <= '0;
            k          <= '0;
            order_q    <= '0;
            mode_q     <= MODE_FIB;
            stream_q   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            overflow   <= 1'b0;
            data_out   <= '0;
            term_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (load) begin
                        done <= 1'b0;
                        if (mode == MODE_RSV) begin
                            state <= ST_FAULT;
                            error <= 1'b1;
                        end else begin
                            state      <= ST_RUN;
                            acc        <= data_in;
                            prev       <= '0;
                            k          <= '0;
                            mode_q     <= mode;
                            order_q    <= order;
                            stream_q   <= stream;
                            term_valid <= stream;
                        end
                    end
                end
                ST_RUN: begin
                    if (step) begin
                        if (k == order_q) begin
                            state      <= ST_DONE;
                            done       <= 1'b1;
                            data_out   <= acc;
                            term_valid <= 1'b0;
                        end else if (too_big) begin
                            state      <= ST_FAULT;
                            overflow   <= 1'b1;
                            data_out   <= acc;
                            term_valid <= 1'b0;
                        end else begin
                            acc  <= next[DATA_WIDTH-1:0];
                            prev <= acc;
                            k    <= k + ORDER_WIDTH'(1);
                        end
                    end
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen_param.sv
// Directed bench for seq_gen_param. A 64-bit instance covers the normal
// sequences and streaming; an 8-bit instance shares the same stimulus and
// is used to provoke data overflow.
module tb_seq_gen_param;

    logic        clk;
    logic        reset;
    logic        load;
    logic [1:0]  mode;
    logic        stream;
    logic        clear;
    logic [15:0] order;
    logic [63:0] data_in;
    logic        term_ready;

    logic        done;
    logic        error;
    logic        overflow;
    logic [63:0] data_out;
    logic        term_valid;
    logic [63:0] term_out;
    logic [15:0] term_idx;

    logic        done8;
    logic        error8;
    logic        overflow8;
    logic [7:0]  data_out8;
    logic        term_valid8;
    logic [7:0]  term_out8;
    logic [15:0] term_idx8;

    int total;
    int bad;

    seq_gen_param #(.DATA_WIDTH(64), .ORDER_WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .mode      (mode),
        .stream    (stream),
        .clear     (clear),
        .order     (order),
        .data_in   (data_in),
        .done      (done),
        .error     (error),
        .overflow  (overflow),
        .data_out  (data_out),
        .term_valid(term_valid),
        .term_ready(term_ready),
        .term_out  (term_out),
        .term_idx  (term_idx)
    );

    seq_gen_param #(.DATA_WIDTH(8), .ORDER_WIDTH(16)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .mode      (mode),
        .stream    (stream),
        .clear     (clear),
        .order     (order),
        .data_in   (data_in[7:0]),
        .done      (done8),
        .error     (error8),
        .overflow  (overflow8),
        .data_out  (data_out8),
        .term_valid(term_valid8),
        .term_ready(term_ready),
        .term_out  (term_out8),
        .term_idx  (term_idx8)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges the stimulus thread.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expected);
        total++;
        if (got !== expected) begin
            bad++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, expected);
        end
    endtask

    // Advance n rising edges, landing 1 ns after the last one.
    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a load request for exactly one edge (edge E0).
    task automatic applyStimulus(input logic [1:0] md, input logic st, input logic [15:0] ord,
                                 input logic [63:0] seed);
        load    = 1'b1;
        mode    = md;
        stream  = st;
        order   = ord;
        data_in = seed;
        waitCycles(1);
        load    = 1'b0;
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        waitCycles(1);
        clear = 1'b0;
    endtask

    // Main directed sequence with hand-computed expectations.
    initial begin
        logic [63:0] exp_terms [6];
        int idx;

        exp_terms = '{64'd2, 64'd2, 64'd4, 64'd6, 64'd10, 64'd16};
        total = 0;
        bad   = 0;
        reset = 1'b1;
        load = 1'b0; mode = 2'd0; stream = 1'b0; clear = 1'b0;
        order = '0; data_in = '0; term_ready = 1'b0;
        waitCycles(2);
        reset = 1'b0;

        checkOutput("rst_done", {63'd0, done}, 64'd0);
        checkOutput("rst_error", {63'd0, error}, 64'd0);
        checkOutput("rst_overflow", {63'd0, overflow}, 64'd0);
        checkOutput("rst_data_out", data_out, 64'd0);
        checkOutput("rst_term_valid", {63'd0, term_valid}, 64'd0);

        // FIB s=1 order=10: 89 at E0+11
        applyStimulus(2'd0, 1'b0, 16'd10, 64'd1);
        waitCycles(10);
        checkOutput("fib_early_done", {63'd0, done}, 64'd0);
        checkOutput("fib_nostream_valid", {63'd0, term_valid}, 64'd0);
        waitCycles(1);
        checkOutput("fib_done", {63'd0, done}, 64'd1);
        checkOutput("fib_data", data_out, 64'd89);
        checkOutput("fib_error", {63'd0, error}, 64'd0);
        checkOutput("fib_overflow", {63'd0, overflow}, 64'd0);

        // TRI s=0 order=4 -> 10, loaded straight from DONE
        applyStimulus(2'd1, 1'b0, 16'd4, 64'd0);
        checkOutput("tri_done_drop", {63'd0, done}, 64'd0);
        waitCycles(5);
        checkOutput("tri_done", {63'd0, done}, 64'd1);
        checkOutput("tri_data", data_out, 64'd10);

        // SQR s=0 order=5 -> 25
        applyStimulus(2'd2, 1'b0, 16'd5, 64'd0);
        waitCycles(6);
        checkOutput("sqr_done", {63'd0, done}, 64'd1);
        checkOutput("sqr_data", data_out, 64'd25);

        // order=0 s=7 -> 7 at E0+1
        applyStimulus(2'd1, 1'b0, 16'd0, 64'd7);
        waitCycles(1);
        checkOutput("ord0_done", {63'd0, done}, 64'd1);
        checkOutput("ord0_data", data_out, 64'd7);

        // 8-bit FIB overflow: 233 + 144 does not fit, trips at E0+13
        pulseClear();
        applyStimulus(2'd0, 1'b0, 16'd20, 64'd1);
        waitCycles(12);
        checkOutput("ovf_early", {63'd0, overflow8}, 64'd0);
        waitCycles(1);
        checkOutput("ovf_flag", {63'd0, overflow8}, 64'd1);
        checkOutput("ovf_data", {56'd0, data_out8}, 64'd233);
        checkOutput("ovf_done", {63'd0, done8}, 64'd0);
        checkOutput("ovf_error", {63'd0, error8}, 64'd0);
        waitCycles(8);
        checkOutput("fib20_done", {63'd0, done}, 64'd1);
        checkOutput("fib20_data", data_out, 64'd10946);
        applyStimulus(2'd0, 1'b0, 16'd1, 64'd1);
        waitCycles(3);
        checkOutput("ovf_load_ignored_done", {63'd0, done8}, 64'd0);
        checkOutput("ovf_sticky", {63'd0, overflow8}, 64'd1);
        checkOutput("ovf_data_held", {56'd0, data_out8}, 64'd233);
        pulseClear();
        checkOutput("clr_overflow", {63'd0, overflow8}, 64'd0);
        checkOutput("clr_data_out", {56'd0, data_out8}, 64'd0);
        checkOutput("clr_term_out", {56'd0, term_out8}, 64'd0);
        checkOutput("clr_term_idx", {48'd0, term_idx8}, 64'd0);
        checkOutput("clr_done", {63'd0, done8}, 64'd0);

        // Reserved mode -> sticky error, then clear and a clean FIB run
        applyStimulus(2'd3, 1'b0, 16'd4, 64'd1);
        checkOutput("rsv_error", {63'd0, error}, 64'd1);
        checkOutput("rsv_done", {63'd0, done}, 64'd0);
        waitCycles(2);
        checkOutput("rsv_sticky", {63'd0, error}, 64'd1);
        pulseClear();
        checkOutput("rsv_cleared", {63'd0, error}, 64'd0);
        applyStimulus(2'd0, 1'b0, 16'd2, 64'd3);
        waitCycles(3);
        checkOutput("post_rsv_done", {63'd0, done}, 64'd1);
        checkOutput("post_rsv_data", data_out, 64'd6);

        // Streaming FIB s=2 order=5 with ready toggling 1,0,1,0...
        applyStimulus(2'd0, 1'b1, 16'd5, 64'd2);
        idx = 0;
        for (int c = 0; c < 20 && idx < 6; c++) begin
            term_ready = (c % 2 == 0);
            checkOutput("strm_valid", {63'd0, term_valid}, 64'd1);
            checkOutput("strm_term", term_out, exp_terms[idx]);
            checkOutput("strm_idx", {48'd0, term_idx}, 64'(idx));
            if (term_ready) idx++;
            waitCycles(1);
        end
        term_ready = 1'b0;
        checkOutput("strm_count", 64'(idx), 64'd6);
        checkOutput("strm_done", {63'd0, done}, 64'd1);
        checkOutput("strm_data", data_out, 64'd16);
        checkOutput("strm_valid_off", {63'd0, term_valid}, 64'd0);

        // Reset at k=3 of an order=50 run, then immediate reload
        applyStimulus(2'd0, 1'b0, 16'd50, 64'd1);
        waitCycles(3);
        checkOutput("mid_idx", {48'd0, term_idx}, 64'd3);
        checkOutput("mid_term", term_out, 64'd3);
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
        checkOutput("mrst_idx", {48'd0, term_idx}, 64'd0);
        checkOutput("mrst_term", term_out, 64'd0);
        checkOutput("mrst_data", data_out, 64'd0);
        checkOutput("mrst_done", {63'd0, done}, 64'd0);
        applyStimulus(2'd0, 1'b0, 16'd1, 64'd5);
        waitCycles(1);
        checkOutput("reload_early", {63'd0, done}, 64'd0);
        waitCycles(1);
        checkOutput("reload_done", {63'd0, done}, 64'd1);
        checkOutput("reload_data", data_out, 64'd5);

        // load together with clear in IDLE must not start a run
        pulseClear();
        clear = 1'b1;
        applyStimulus(2'd0, 1'b0, 16'd0, 64'd9);
        clear = 1'b0;
        waitCycles(2);
        checkOutput("ldclr_done", {63'd0, done}, 64'd0);
        checkOutput("ldclr_data", data_out, 64'd0);
        checkOutput("ldclr_term", term_out, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
